// File: rtl/ysyx_25040105_mc_core.sv
// ysyx_25040105_mc_core
// Multi-cycle RV32I/RV32E subset core. Each instruction is fetched over a
// valid/ready request channel plus a valid-only response channel, executed in
// one cycle, and written back to an internal register file. EBREAK halts the
// core with the value of a0 as exit code; illegal encodings, out-of-range
// register indices and misaligned jump targets halt it with trap set.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous reset, active low
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_addr       fetch address (current pc)
//   imem_rsp_valid  instruction data valid
//   imem_rsp_data   fetched instruction
//   retire_valid    one-cycle pulse per retired instruction
//   retire_pc       pc of the retired instruction
//   retire_inst     encoding of the retired instruction
//   instret         retired-instruction count (wraps)
//   halted          core stopped (EBREAK or trap)
//   trap            stop caused by an illegal instruction or misaligned target
//   exit_code       a0 (x10) captured at EBREAK
//   dbg_raddr       debug register index
//   dbg_rdata       combinational read of dbg_raddr (0 for x0 / out of range)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_REQ  | request valid, address = pc, wait for ready
// FETCH_WAIT | request accepted, wait for the instruction response
// EXEC       | decode, execute, write back, retire (exactly one cycle)
// HALT       | terminal until reset; debug port stays live
module ysyx_25040105_mc_core #(
  parameter int          NR_REGS  = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             retire_valid,
  output logic [31:0]      retire_pc,
  output logic [31:0]      retire_inst,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             trap,
  output logic [31:0]      exit_code,
  input  logic [4:0]       dbg_raddr,
  output logic [31:0]      dbg_rdata
);

  localparam int RW = (NR_REGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXEC       = 2'd2,
    HALT       = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        req_valid_q;
  logic [31:0] regs [NR_REGS];

  // An index is architecturally present only below NR_REGS; for RV32E that
  // means bit 4 must be clear.
  function automatic logic reg_ok(input logic [4:0] idx);
    reg_ok = (NR_REGS == 32) || !idx[4];
  endfunction

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_j;
  logic [RW-1:0] rd_i, rs1_i, rs2_i, dbg_i;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rd_i  = rd[RW-1:0];
  assign rs1_i = rs1[RW-1:0];
  assign rs2_i = rs2[RW-1:0];
  assign dbg_i = dbg_raddr[RW-1:0];

  // Register reads; out-of-range indices read 0 so that an illegal
  // instruction never indexes past the array.
  logic [31:0] rs1_val, rs2_val, a0_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    dbg_rdata = '0;
    if (rs1 != 5'd0 && reg_ok(rs1))
      rs1_val = regs[rs1_i];
    if (rs2 != 5'd0 && reg_ok(rs2))
      rs2_val = regs[rs2_i];
    if (dbg_raddr != 5'd0 && reg_ok(dbg_raddr))
      dbg_rdata = regs[dbg_i];
  end

  assign a0_val = regs[10];

  // Decode / execute
  logic        legal;
  logic        is_ebreak;
  logic        is_jump;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        use_rs1, use_rs2, use_rd;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    is_jump   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    next_pc   = pc_plus4;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == 3'b000) begin
          legal   = 1'b1;
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          wr_en   = 1'b1;
          wr_data = rs1_val + imm_i;
        end
      end
      OPC_OP: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          legal   = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          use_rd  = 1'b1;
          wr_en   = 1'b1;
          wr_data = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
        end
      end
      OPC_LUI: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      OPC_JAL: begin
        legal   = 1'b1;
        is_jump = 1'b1;
        use_rd  = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          legal   = 1'b1;
          is_jump = 1'b1;
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          wr_en   = 1'b1;
          wr_data = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_SYSTEM: begin
        if (ir == INST_EBREAK) begin
          legal     = 1'b1;
          is_ebreak = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase

    // Only fields the instruction actually uses are range-checked; the
    // same bit positions are immediate bits for U/J formats.
    if ((use_rs1 && !reg_ok(rs1)) || (use_rs2 && !reg_ok(rs2)) ||
        (use_rd && !reg_ok(rd)))
      legal = 1'b0;
    if (is_jump && next_pc[1])
      legal = 1'b0;
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH_REQ;
      pc           <= RESET_PC;
      ir           <= '0;
      req_valid_q  <= 1'b0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_inst  <= '0;
      instret      <= '0;
      halted       <= 1'b0;
      trap         <= 1'b0;
      exit_code    <= '0;
      for (int i = 0; i < NR_REGS; i++)
        regs[i] <= '0;
    end else begin
      retire_valid <= 1'b0;
      case (state)
        FETCH_REQ: begin
          // The first cycle after reset release only raises valid.
          if (req_valid_q && imem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= FETCH_WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            ir    <= imem_rsp_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!legal) begin
            halted <= 1'b1;
            trap   <= 1'b1;
            state  <= HALT;
          end else begin
            retire_valid <= 1'b1;
            retire_pc    <= pc;
            retire_inst  <= ir;
            instret      <= instret + CNT_W'(1);
            pc           <= next_pc;
            if (wr_en && rd != 5'd0)
              regs[rd_i] <= wr_data;
            if (is_ebreak) begin
              exit_code <= a0_val;
              halted    <= 1'b1;
              state     <= HALT;
            end else begin
              req_valid_q <= 1'b1;
              state       <= FETCH_REQ;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule
